// File: rtl/pulse_timing_monitor.sv
// Laser trigger pulse monitor: measures high width and rising-to-rising
// period of the synchronized trigger, raises sticky faults against live
// limits, and drives the status byte and the laser permit.
module pulse_timing_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             pulse_in,
    input  logic             enable,
    input  logic             clear_faults,
    input  logic [CNT_W-1:0] pulse_width_lower_limit,
    input  logic [CNT_W-1:0] pulse_width_upper_limit,
    input  logic [CNT_W-1:0] rate_lower_limit,
    output logic [CNT_W-1:0] last_width,
    output logic [CNT_W-1:0] last_period,
    output logic [7:0]       monitor_status,
    output logic             laser_ok
);

    // Fewer than two synchronizer flops is never safe; clamp silently.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic [SYNC_N-1:0] sync_p;
    logic              prev_p;
    logic              pulse_s;
    logic              rise;
    logic              fall;

    state_t            state;
    logic [CNT_W-1:0]  width_cnt;
    logic [CNT_W-1:0]  period_cnt;
    logic              first_seen;
    logic              fault_short;
    logic              fault_long;
    logic              fault_rate;
    logic              sat;
    logic              en_q;

    logic              short_evt;
    logic              long_evt;
    logic              rate_evt;
    logic              sat_evt;

    // Pin synchronizer followed by one history flop for edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_p <= '0;
            prev_p <= 1'b0;
        end else begin
            sync_p <= {sync_p[SYNC_N-2:0], pulse_in};
            prev_p <= sync_p[SYNC_N-1];
        end
    end

    assign pulse_s = sync_p[SYNC_N-1];
    assign rise    = pulse_s & ~prev_p;
    assign fall    = ~pulse_s & prev_p;

    // Fault and saturation conditions evaluated against live limits.
    always_comb begin
        short_evt = 1'b0;
        long_evt  = 1'b0;
        rate_evt  = 1'b0;
        sat_evt   = 1'b0;
        if (enable) begin
            case (state)
                HIGH: begin
                    // Comparing the current count against the limit flags the
                    // cycle the count steps to limit+1, without an adder that
                    // could overflow.
                    short_evt = fall && (pulse_width_lower_limit != '0) &&
                                (width_cnt < pulse_width_lower_limit);
                    long_evt  = !fall && (pulse_width_upper_limit != '0) &&
                                (width_cnt >= pulse_width_upper_limit);
                    sat_evt   = (period_cnt == CNT_MAX) ||
                                (!fall && (width_cnt == CNT_MAX));
                end
                LOW: begin
                    rate_evt  = rise && (rate_lower_limit != '0) &&
                                (period_cnt < rate_lower_limit);
                    sat_evt   = !rise && (period_cnt == CNT_MAX);
                end
                default: ;
            endcase
        end
    end

    // Measurement FSM with sticky faults (a new fault beats a same-cycle clear).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            width_cnt   <= '0;
            period_cnt  <= '0;
            first_seen  <= 1'b0;
            last_width  <= '0;
            last_period <= '0;
            fault_short <= 1'b0;
            fault_long  <= 1'b0;
            fault_rate  <= 1'b0;
            sat         <= 1'b0;
            en_q        <= 1'b0;
            laser_ok    <= 1'b0;
        end else begin
            fault_short <= short_evt | (fault_short & ~clear_faults);
            fault_long  <= long_evt  | (fault_long  & ~clear_faults);
            fault_rate  <= rate_evt  | (fault_rate  & ~clear_faults);
            sat         <= sat_evt   | (sat         & ~clear_faults);
            en_q        <= enable;
            laser_ok    <= enable & ~(fault_short | fault_long | fault_rate);

            if (!enable) begin
                // Any pulse in progress is dropped; last_* are kept.
                state      <= IDLE;
                width_cnt  <= '0;
                period_cnt <= '0;
                first_seen <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state      <= HIGH;
                            width_cnt  <= CNT_ONE;
                            period_cnt <= CNT_ONE;
                            first_seen <= 1'b1;
                        end
                    end
                    HIGH: begin
                        period_cnt <= sat_inc(period_cnt);
                        if (fall) begin
                            last_width <= width_cnt;
                            state      <= LOW;
                        end else begin
                            width_cnt  <= sat_inc(width_cnt);
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            last_period <= period_cnt;
                            width_cnt   <= CNT_ONE;
                            period_cnt  <= CNT_ONE;
                            state       <= HIGH;
                        end else begin
                            period_cnt  <= sat_inc(period_cnt);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign monitor_status = {1'b0, en_q, sat, first_seen, (state == HIGH),
                             fault_rate, fault_long, fault_short};

endmodule
